// File: rtl/piano_mode_controller.sv
// Piano mode controller: arbitrates free play, auto playback and learn mode
// for NUM_KEYS keys. A mode change mutes the outputs for a fixed window before
// the new mode takes over. Learn mode scores key presses against the note
// expected by the song sequencer.
module piano_mode_controller #(
   parameter int NUM_KEYS = 7,
   parameter int NOTE_W   = 4,
   parameter int SCORE_W  = 8,
   parameter int MUTE_CYC = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic [2:0]          mode,
   input  logic [NOTE_W-1:0]   auto_note,
   input  logic [NUM_KEYS-1:0] auto_led,
   output logic                auto_restart,
   input  logic [NOTE_W-1:0]   learn_note,
   output logic                learn_advance,
   output logic [NOTE_W-1:0]   note_out,
   output logic [NUM_KEYS-1:0] led_out,
   output logic [SCORE_W-1:0]  score,
   output logic [SCORE_W-1:0]  miss_cnt
);

   localparam int CNT_W = $clog2(MUTE_CYC + 1);

   typedef enum logic [2:0] {T_MUTE, T_FREE, T_AUTO, T_LEARN, T_BAD} top_t;
   typedef enum logic [2:0] {L_SHOW, L_REL_OK, L_REL_BAD, L_SYNC, L_DONE} learn_t;

   // Note code of the lowest pressed key (key i -> i+1), 0 when none pressed.
   function automatic logic [NOTE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] k);
      logic [NOTE_W-1:0] idx;
      idx = {NOTE_W{1'b0}};
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         idx = k[i] ? NOTE_W'(i + 1) : idx;
      end
      return idx;
   endfunction

   // One-hot LED pattern for a note code; all zero for code 0.
   function automatic logic [NUM_KEYS-1:0] note_led(input logic [NOTE_W-1:0] n);
      logic [NUM_KEYS-1:0] led;
      for (int i = 0; i < NUM_KEYS; i++) begin
         led[i] = (n == NOTE_W'(i + 1));
      end
      return led;
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
   endfunction

   top_t                r_top;
   learn_t              r_lst;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_KEYS-1:0] r_key_q;
   logic [2:0]          r_mode_q;
   logic [NOTE_W-1:0]   r_note;
   logic [NUM_KEYS-1:0] r_led;
   logic                r_restart;
   logic                r_adv;
   logic [SCORE_W-1:0]  r_score;
   logic [SCORE_W-1:0]  r_miss;

   top_t                w_top_nxt;
   learn_t              w_lst_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [NOTE_W-1:0]   w_note_nxt;
   logic [NUM_KEYS-1:0] w_led_nxt;
   logic                w_restart_nxt;
   logic                w_adv_nxt;
   logic [SCORE_W-1:0]  w_score_nxt;
   logic [SCORE_W-1:0]  w_miss_nxt;
   logic [NOTE_W-1:0]   w_pidx;
   logic [NOTE_W-1:0]   w_ln;
   logic [NUM_KEYS-1:0] w_exp_led;

   // Pressed-key index and sanitised expected note (out-of-range means song over).
   always_comb begin
      w_pidx    = lowest_idx(r_key_q);
      w_ln      = (learn_note > NOTE_W'(NUM_KEYS)) ? {NOTE_W{1'b0}} : learn_note;
      w_exp_led = note_led(w_ln);
   end

   // Next-state and next-output logic for the mode FSM and the learn sub-FSM.
   always_comb begin
      w_top_nxt     = r_top;
      w_lst_nxt     = r_lst;
      w_cnt_nxt     = r_cnt;
      w_note_nxt    = r_note;
      w_led_nxt     = r_led;
      w_restart_nxt = 1'b0;
      w_adv_nxt     = 1'b0;
      w_score_nxt   = r_score;
      w_miss_nxt    = r_miss;
      if (mode != r_mode_q) begin
         // A mode change wins over everything, including a pending release.
         w_top_nxt  = T_MUTE;
         w_cnt_nxt  = CNT_W'(MUTE_CYC);
         w_note_nxt = {NOTE_W{1'b0}};
         w_led_nxt  = {NUM_KEYS{1'b0}};
      end else begin
         case (r_top)
            T_MUTE: begin
               w_note_nxt = {NOTE_W{1'b0}};
               w_led_nxt  = {NUM_KEYS{1'b0}};
               if (r_cnt == {CNT_W{1'b0}}) begin
                  case (r_mode_q)
                     3'b100: w_top_nxt = T_FREE;
                     3'b010: begin
                        w_top_nxt     = T_AUTO;
                        w_restart_nxt = 1'b1;
                     end
                     3'b001: begin
                        w_top_nxt   = T_LEARN;
                        w_lst_nxt   = L_SHOW;
                        w_score_nxt = {SCORE_W{1'b0}};
                        w_miss_nxt  = {SCORE_W{1'b0}};
                     end
                     default: w_top_nxt = T_BAD;
                  endcase
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            T_FREE: begin
               w_note_nxt = w_pidx;
               w_led_nxt  = r_key_q;
            end
            T_AUTO: begin
               w_note_nxt = auto_note;
               w_led_nxt  = auto_led;
            end
            T_BAD: begin
               // The counter free-runs here; its LSB drives the blink.
               w_note_nxt = {NOTE_W{1'b0}};
               w_led_nxt  = {NUM_KEYS{r_cnt[0]}};
               w_cnt_nxt  = r_cnt - CNT_W'(1);
            end
            T_LEARN: begin
               case (r_lst)
                  L_SHOW: begin
                     w_note_nxt = {NOTE_W{1'b0}};
                     if (w_ln == {NOTE_W{1'b0}}) begin
                        w_led_nxt = {NUM_KEYS{1'b1}};
                        w_lst_nxt = L_DONE;
                     end else begin
                        w_led_nxt = w_exp_led;
                        if (w_pidx == {NOTE_W{1'b0}}) begin
                           w_lst_nxt = L_SHOW;
                        end else if (w_pidx == w_ln) begin
                           w_score_nxt = sat_inc(r_score);
                           w_note_nxt  = w_pidx;
                           w_lst_nxt   = L_REL_OK;
                        end else begin
                           w_miss_nxt = sat_inc(r_miss);
                           w_note_nxt = w_pidx;
                           w_lst_nxt  = L_REL_BAD;
                        end
                     end
                  end
                  L_REL_OK: begin
                     if (r_key_q == {NUM_KEYS{1'b0}}) begin
                        w_note_nxt = {NOTE_W{1'b0}};
                        w_adv_nxt  = 1'b1;
                        w_lst_nxt  = L_SYNC;
                     end else begin
                        w_lst_nxt = L_REL_OK;
                     end
                  end
                  L_REL_BAD: begin
                     if (r_key_q == {NUM_KEYS{1'b0}}) begin
                        w_note_nxt = {NOTE_W{1'b0}};
                        w_lst_nxt  = L_SHOW;
                     end else begin
                        w_lst_nxt = L_REL_BAD;
                     end
                  end
                  L_SYNC: begin
                     // Give the sequencer a cycle to present the next note.
                     w_note_nxt = {NOTE_W{1'b0}};
                     w_lst_nxt  = L_SHOW;
                  end
                  L_DONE: begin
                     w_note_nxt = {NOTE_W{1'b0}};
                     w_led_nxt  = {NUM_KEYS{1'b1}};
                  end
                  default: w_lst_nxt = L_SHOW;
               endcase
            end
            default: begin
               w_top_nxt  = T_MUTE;
               w_cnt_nxt  = CNT_W'(MUTE_CYC);
               w_note_nxt = {NOTE_W{1'b0}};
               w_led_nxt  = {NUM_KEYS{1'b0}};
            end
         endcase
      end
   end

   // State, input capture and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_top     <= T_MUTE;
         r_lst     <= L_SHOW;
         r_cnt     <= CNT_W'(MUTE_CYC);
         r_key_q   <= {NUM_KEYS{1'b0}};
         r_mode_q  <= mode;
         r_note    <= {NOTE_W{1'b0}};
         r_led     <= {NUM_KEYS{1'b0}};
         r_restart <= 1'b0;
         r_adv     <= 1'b0;
         r_score   <= {SCORE_W{1'b0}};
         r_miss    <= {SCORE_W{1'b0}};
      end else begin
         r_top     <= w_top_nxt;
         r_lst     <= w_lst_nxt;
         r_cnt     <= w_cnt_nxt;
         r_key_q   <= keys;
         r_mode_q  <= mode;
         r_note    <= w_note_nxt;
         r_led     <= w_led_nxt;
         r_restart <= w_restart_nxt;
         r_adv     <= w_adv_nxt;
         r_score   <= w_score_nxt;
         r_miss    <= w_miss_nxt;
      end
   end

   assign auto_restart  = r_restart;
   assign learn_advance = r_adv;
   assign note_out      = r_note;
   assign led_out       = r_led;
   assign score         = r_score;
   assign miss_cnt      = r_miss;

endmodule

// File: tb/tb_piano_mode_controller.sv
// Scenario-driven bench for piano_mode_controller with an output scoreboard.
module tb_piano_mode_controller;

   localparam int NK = 7;
   localparam int NW = 4;
   localparam int SW = 2;
   localparam int MC = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] keys;
   logic [2:0]    mode;
   logic [NW-1:0] auto_note;
   logic [NK-1:0] auto_led;
   logic          auto_restart;
   logic [NW-1:0] learn_note;
   logic          learn_advance;
   logic [NW-1:0] note_out;
   logic [NK-1:0] led_out;
   logic [SW-1:0] score;
   logic [SW-1:0] miss_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [NW+NK-1:0] sb_q[$];
   logic [NW+NK-1:0] exp_v;

   piano_mode_controller #(
      .NUM_KEYS(NK), .NOTE_W(NW), .SCORE_W(SW), .MUTE_CYC(MC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .keys(keys), .mode(mode),
      .auto_note(auto_note), .auto_led(auto_led), .auto_restart(auto_restart),
      .learn_note(learn_note), .learn_advance(learn_advance),
      .note_out(note_out), .led_out(led_out), .score(score), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 3'b100; keys = '0;
      auto_note = '0; auto_led = '0; learn_note = '0;
      tick(2);
      n_cmp++;
      if ({note_out, led_out, auto_restart, learn_advance, score, miss_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_outs: got %h required 0",
                  {note_out, led_out, auto_restart, learn_advance, score, miss_cnt});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_free();
      keys = 7'b0000100;
      sb_q.push_back({4'd3, 7'b0000100});
      tick(MC + 3);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL free_single: got %h required %h", {note_out, led_out}, exp_v);
      end
      keys = 7'b0000001;
      sb_q.push_back({4'd3, 7'b0000100});
      sb_q.push_back({4'd1, 7'b0000001});
      for (int k = 0; k < 2; k++) begin
         tick(1);
         exp_v = sb_q.pop_front(); n_cmp++;
         if ({note_out, led_out} !== exp_v) begin
            n_bad++; $display("FAIL free_latency%0d: got %h required %h", k + 1, {note_out, led_out}, exp_v);
         end
      end
      keys = 7'b0100100;
      sb_q.push_back({4'd3, 7'b0100100});
      tick(2);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL free_multi: got %h required %h", {note_out, led_out}, exp_v);
      end
   endtask

   task automatic test_auto();
      auto_note = 4'd5; auto_led = 7'b0000101; mode = 3'b010;
      for (int k = 0; k <= MC; k++) begin
         tick(1); n_cmp++;
         if ({note_out, led_out, auto_restart} !== '0) begin
            n_bad++; $display("FAIL auto_mute[%0d]: got note %0d led %b restart %b required 0", k, note_out, led_out, auto_restart);
         end
      end
      tick(1); n_cmp++;
      if ({note_out, auto_restart} !== {4'd0, 1'b1}) begin
         n_bad++; $display("FAIL auto_restart_pulse: got note %0d restart %b required 0/1", note_out, auto_restart);
      end
      sb_q.push_back({4'd5, 7'b0000101});
      tick(1);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, auto_restart} !== {exp_v, 1'b0}) begin
         n_bad++; $display("FAIL auto_track: got %h/%b required %h/0", {note_out, led_out}, auto_restart, exp_v);
      end
      auto_note = 4'd2; auto_led = 7'b0000010;
      sb_q.push_back({4'd2, 7'b0000010});
      tick(1);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL auto_latency: got %h required %h", {note_out, led_out}, exp_v);
      end
      keys = '0;
   endtask

   task automatic test_learn_basic();
      mode = 3'b001; learn_note = 4'd2;
      sb_q.push_back({4'd0, 7'b0000010});
      tick(MC + 3);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score, miss_cnt} !== {exp_v, 2'd0, 2'd0}) begin
         n_bad++; $display("FAIL learn_show: got %h s%0d m%0d required %h s0 m0", {note_out, led_out}, score, miss_cnt, exp_v);
      end
      keys = 7'b0000010;
      sb_q.push_back({4'd2, 7'b0000010});
      tick(2);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score} !== {exp_v, 2'd1}) begin
         n_bad++; $display("FAIL learn_hit: got %h score %0d required %h score 1", {note_out, led_out}, score, exp_v);
      end
      keys = '0;
      tick(1); n_cmp++;
      if (learn_advance !== 1'b0) begin
         n_bad++; $display("FAIL adv_early: got %b required 0", learn_advance);
      end
      tick(1); n_cmp++;
      if ({learn_advance, note_out} !== {1'b1, 4'd0}) begin
         n_bad++; $display("FAIL adv_pulse: got adv %b note %0d required 1/0", learn_advance, note_out);
      end
      learn_note = 4'd6;
      tick(1); n_cmp++;
      if (learn_advance !== 1'b0) begin
         n_bad++; $display("FAIL adv_single: got %b required 0", learn_advance);
      end
      sb_q.push_back({4'd0, 7'b0100000});
      tick(1);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL learn_next: got %h required %h", {note_out, led_out}, exp_v);
      end
   endtask

   task automatic test_learn_wrong();
      learn_note = 4'd4;
      tick(2);
      keys = 7'b0000001;
      sb_q.push_back({4'd1, 7'b0001000});
      tick(2);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score, miss_cnt} !== {exp_v, 2'd1, 2'd1}) begin
         n_bad++; $display("FAIL wrong_press: got %h s%0d m%0d required %h s1 m1", {note_out, led_out}, score, miss_cnt, exp_v);
      end
      keys = '0;
      sb_q.push_back({4'd0, 7'b0001000});
      for (int k = 0; k < 3; k++) begin
         tick(1); n_cmp++;
         if (learn_advance !== 1'b0) begin
            n_bad++; $display("FAIL wrong_no_adv[%0d]: got %b required 0", k, learn_advance);
         end
      end
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL wrong_release: got %h required %h", {note_out, led_out}, exp_v);
      end
      keys = 7'b0001000;
      sb_q.push_back({4'd4, 7'b0001000});
      tick(2);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score} !== {exp_v, 2'd2}) begin
         n_bad++; $display("FAIL right_press: got %h score %0d required %h score 2", {note_out, led_out}, score, exp_v);
      end
      keys = '0;
      tick(2); n_cmp++;
      if (learn_advance !== 1'b1) begin
         n_bad++; $display("FAIL right_adv: got %b required 1", learn_advance);
      end
      learn_note = 4'd0;
      tick(1);
      sb_q.push_back({4'd0, 7'h7f});
      sb_q.push_back({4'd0, 7'h7f});
      tick(1);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL learn_done: got %h required %h", {note_out, led_out}, exp_v);
      end
      tick(3);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score, miss_cnt} !== {exp_v, 2'd2, 2'd1}) begin
         n_bad++; $display("FAIL done_hold: got %h s%0d m%0d required %h s2 m1", {note_out, led_out}, score, miss_cnt, exp_v);
      end
   endtask

   task automatic test_reenter();
      mode = 3'b100;
      tick(MC + 3); n_cmp++;
      if ({score, miss_cnt} !== {2'd2, 2'd1}) begin
         n_bad++; $display("FAIL hold_after_leave: got s%0d m%0d required s2 m1", score, miss_cnt);
      end
      mode = 3'b001; learn_note = 4'd3;
      sb_q.push_back({4'd0, 7'b0000100});
      tick(MC + 3);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out, score, miss_cnt} !== {exp_v, 2'd0, 2'd0}) begin
         n_bad++; $display("FAIL clear_on_entry: got %h s%0d m%0d required %h s0 m0", {note_out, led_out}, score, miss_cnt, exp_v);
      end
   endtask

   task automatic test_saturation();
      logic [SW-1:0] exp_s;
      for (int p = 1; p <= 5; p++) begin
         keys = 7'b0000100;
         exp_s = (p > 3) ? 2'd3 : 2'(p);
         tick(2); n_cmp++;
         if (score !== exp_s) begin
            n_bad++; $display("FAIL score_sat[%0d]: got %0d required %0d", p, score, exp_s);
         end
         keys = '0;
         tick(2); n_cmp++;
         if (learn_advance !== 1'b1) begin
            n_bad++; $display("FAIL sat_adv[%0d]: got %b required 1", p, learn_advance);
         end
         tick(2);
      end
      learn_note = 4'd8;
      sb_q.push_back({4'd0, 7'h7f});
      tick(2);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({note_out, led_out} !== exp_v) begin
         n_bad++; $display("FAIL out_of_range_done: got %h required %h", {note_out, led_out}, exp_v);
      end
   endtask

   task automatic test_mid_mute();
      mode = 3'b100;
      tick(6);
      mode = 3'b010; auto_note = 4'd7; auto_led = '0;
      for (int k = 0; k <= MC; k++) begin
         tick(1); n_cmp++;
         if ({note_out, auto_restart} !== '0) begin
            n_bad++; $display("FAIL midmute_hold[%0d]: got note %0d restart %b required 0", k, note_out, auto_restart);
         end
      end
      tick(1); n_cmp++;
      if (auto_restart !== 1'b1) begin
         n_bad++; $display("FAIL midmute_restart: got %b required 1", auto_restart);
      end
   endtask

   task automatic test_bad();
      logic [NK-1:0] prev;
      mode = 3'b011;
      tick(MC + 4);
      prev = led_out; n_cmp++;
      if (!(prev == 7'h00 || prev == 7'h7f) || note_out !== 4'd0) begin
         n_bad++; $display("FAIL bad_entry: got led %b note %0d required all-0/all-1 and 0", prev, note_out);
      end
      for (int k = 0; k < 4; k++) begin
         tick(1); n_cmp++;
         if ({note_out, led_out} !== {4'd0, ~prev}) begin
            n_bad++; $display("FAIL bad_blink[%0d]: got note %0d led %b required 0 %b", k, note_out, led_out, ~prev);
         end
         prev = led_out;
      end
   endtask

   task automatic test_reset_rel_ok();
      mode = 3'b001; learn_note = 4'd5;
      tick(MC + 3);
      keys = 7'b0010000;
      tick(2); n_cmp++;
      if ({note_out, score} !== {4'd5, 2'd1}) begin
         n_bad++; $display("FAIL relok_setup: got note %0d score %0d required 5/1", note_out, score);
      end
      rst_n = 1'b0; keys = '0;
      tick(1); n_cmp++;
      if ({note_out, led_out, auto_restart, learn_advance, score, miss_cnt} !== '0) begin
         n_bad++; $display("FAIL relok_reset: got %h required 0",
                           {note_out, led_out, auto_restart, learn_advance, score, miss_cnt});
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1); n_cmp++;
         if ({learn_advance, note_out} !== '0) begin
            n_bad++; $display("FAIL post_reset_adv[%0d]: got adv %b note %0d required 0", k, learn_advance, note_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free();
      test_auto();
      test_learn_basic();
      test_learn_wrong();
      test_reenter();
      test_saturation();
      test_mid_mute();
      test_bad();
      test_reset_rel_ok();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
